pcm_frame_pingpong_ctrl: RTL and testbench

- Sequences the PCM sample stream (data/data_valid from the PCM source) into a two-bank ping-pong BRAM, one frame per bank.
- Hands each completed frame to the downstream equalizer consumer with a ready/ack handshake.
- Tracks bank ownership and counts samples dropped when both banks are full.
- Sits between the PCM source and the BRAM write port; the consumer reads BRAM directly through its own port.

---
 rtl/pcm_frame_pingpong_ctrl.sv | 93 +++++++++
 tb/tb_pcm_frame_pingpong_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_frame_pingpong_ctrl.sv
// rtl/pcm_frame_pingpong_ctrl.sv - PCM sample sequencer into a two-bank ping-pong BRAM with frame handshake
module pcm_frame_pingpong_ctrl #(
    parameter int BIT_DEPTH = 8,
    parameter int FRAME_LEN = 256,
    localparam int AW = $clog2(FRAME_LEN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [BIT_DEPTH-1:0] in_data,
    input  logic                        in_valid,
    output logic                        bram_we,
    output logic [AW:0]                 bram_waddr,
    output logic [BIT_DEPTH-1:0]        bram_wdata,
    output logic                        frame_ready,
    output logic                        frame_bank,
    input  logic                        frame_ack,
    output logic                        overrun,
    input  logic                        clr_overrun,
    output logic [15:0]                 drop_cnt
);

    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

    logic          wr_bank;
    logic [AW-1:0] wr_cnt;
    logic [1:0]    full;
    logic [1:0]    full_next;
    logic          rd_bank;
    logic          pending;
    logic          pend_bank;
    logic          accept;
    logic          drop;
    logic          ack_ok;

    // A bank that just closed is still off-limits while its full flag is one cycle away.
    assign accept = en & in_valid & ~full[wr_bank] & ~(pending & (pend_bank == wr_bank));
    assign drop   = en & in_valid & ~accept;
    assign ack_ok = frame_ack & full[rd_bank];

    assign frame_ready = full[rd_bank];
    assign frame_bank  = rd_bank;

    always_comb begin
        full_next = full;
        if (pending)
            full_next[pend_bank] = 1'b1;
        if (ack_ok)
            full_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bram_we    <= 1'b0;
            bram_waddr <= '0;
            bram_wdata <= '0;
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            full       <= 2'b00;
            rd_bank    <= 1'b0;
            pending    <= 1'b0;
            pend_bank  <= 1'b0;
            overrun    <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            bram_we <= accept;
            pending <= accept && (wr_cnt == LAST_IDX);
            if (accept) begin
                bram_waddr <= {wr_bank, wr_cnt};
                bram_wdata <= in_data;
                wr_cnt     <= wr_cnt + 1'b1;
                if (wr_cnt == LAST_IDX) begin
                    wr_bank   <= ~wr_bank;
                    pend_bank <= wr_bank;
                end
            end

            full <= full_next;
            if (ack_ok)
                rd_bank <= ~rd_bank;

            if (clr_overrun) begin
                drop_cnt <= '0;
                overrun  <= 1'b0;
            end else if (drop) begin
                overrun <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pcm_frame_pingpong_ctrl.sv
// tb/tb_pcm_frame_pingpong_ctrl.sv - scoreboard bench for pcm_frame_pingpong_ctrl (FRAME_LEN=4, BIT_DEPTH=8)
module tb_pcm_frame_pingpong_ctrl;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic signed [7:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              bram_we;
    logic [2:0]        bram_waddr;
    logic [7:0]        bram_wdata;
    logic              frame_ready;
    logic              frame_bank;
    logic              frame_ack = 1'b0;
    logic              overrun;
    logic              clr_overrun = 1'b0;
    logic [15:0]       drop_cnt;

    typedef struct {
        int         due;
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t q[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    pcm_frame_pingpong_ctrl #(.BIT_DEPTH(8), .FRAME_LEN(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .bram_we     (bram_we),
        .bram_waddr  (bram_waddr),
        .bram_wdata  (bram_wdata),
        .frame_ready (frame_ready),
        .frame_bank  (frame_bank),
        .frame_ack   (frame_ack),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every observed write must match the oldest expected write, in the exact cycle expected.
    always @(negedge clk) begin
        if (rst && bram_we) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%0d cyc=%0d", bram_waddr, bram_wdata, cyc);
            end else begin
                wr_t e;
                e = q.pop_front();
                if (bram_waddr !== e.addr || bram_wdata !== e.data || cyc !== e.due) begin
                    failures++;
                    $display("FAIL write got addr=%0d data=%0d cyc=%0d expected addr=%0d data=%0d cyc=%0d",
                             bram_waddr, bram_wdata, cyc, e.addr, e.data, e.due);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        frame_ack   = 1'b0;
        clr_overrun = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input bit exp, input logic [2:0] a);
        wr_t e;
        step();
        in_valid = 1'b1;
        in_data  = d;
        if (exp) begin
            e.due  = cyc + 1;
            e.addr = a;
            e.data = d;
            q.push_back(e);
        end
    endtask

    task automatic check_frame(input string name, input logic rdy, input logic bank);
        @(negedge clk);
        checks++;
        if (frame_ready !== rdy || (rdy && frame_bank !== bank)) begin
            failures++;
            $display("FAIL %s frame_ready=%b frame_bank=%b expected ready=%b bank=%b",
                     name, frame_ready, frame_bank, rdy, bank);
        end
    endtask

    task automatic check_drop(input string name, input logic [15:0] cnt, input logic ovr);
        @(negedge clk);
        checks++;
        if (drop_cnt !== cnt || overrun !== ovr) begin
            failures++;
            $display("FAIL %s drop_cnt=%0d overrun=%b expected drop_cnt=%0d overrun=%b",
                     name, drop_cnt, overrun, cnt, ovr);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (bram_we !== 1'b0 || bram_waddr !== 3'd0 || bram_wdata !== 8'd0 || frame_ready !== 1'b0 ||
            frame_bank !== 1'b0 || overrun !== 1'b0 || drop_cnt !== 16'd0) begin
            failures++;
            $display("FAIL %s we=%b addr=%0d data=%0d ready=%b bank=%b ovr=%b drop=%0d expected all 0",
                     name, bram_we, bram_waddr, bram_wdata, frame_ready, frame_bank, overrun, drop_cnt);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst = 1'b1;
        en  = 1'b1;
    endtask

    task automatic test_first_frame();
        for (int i = 0; i < 4; i++)
            send(8'(i + 1), 1'b1, 3'(i));
        step();
        check_frame("ready_not_yet", 1'b0, 1'b0);
        step();
        check_frame("ready_two_after_last", 1'b1, 1'b0);
    endtask

    task automatic test_hold_and_ack();
        for (int i = 0; i < 4; i++)
            send(8'(i + 5), 1'b1, 3'(4 + i));
        step();
        check_frame("hold_bank0", 1'b1, 1'b0);
        step();
        step();
        frame_ack = 1'b1;
        step();
        check_frame("after_ack_bank1", 1'b1, 1'b1);
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 4; i++)
            send(8'(i + 9), 1'b1, 3'(i));
        step();
        step();
        for (int i = 0; i < 3; i++)
            send(8'(i + 13), 1'b0, 3'd0);
        step();
        check_drop("three_drops", 16'd3, 1'b1);
        check_frame("both_full_bank1", 1'b1, 1'b1);
        clr_overrun = 1'b1;
        step();
        check_drop("clear", 16'd0, 1'b0);
        send(8'd16, 1'b0, 3'd0);
        clr_overrun = 1'b1;
        step();
        check_drop("clear_beats_drop", 16'd0, 1'b0);
    endtask

    task automatic test_ack_drop();
        frame_ack = 1'b1;
        step();
        check_frame("fill_order_bank0", 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            send(8'(i + 17), 1'b1, 3'(4 + i));
        step();
        step();
        send(8'd9, 1'b0, 3'd0);
        frame_ack = 1'b1;
        send(8'd10, 1'b1, 3'd0);
        step();
        check_drop("ack_same_cycle_drop", 16'd1, 1'b1);
        check_frame("ack_same_cycle_bank1", 1'b1, 1'b1);
    endtask

    task automatic test_async_reset();
        send(8'd11, 1'b0, 3'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        in_valid = 1'b0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic test_en_gap();
        send(8'd20, 1'b1, 3'd0);
        send(8'd21, 1'b1, 3'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            en       = 1'b0;
            in_valid = 1'b1;
            in_data  = 8'd99;
        end
        step();
        en = 1'b1;
        send(8'd22, 1'b1, 3'd2);
        send(8'd23, 1'b1, 3'd3);
        step();
        check_frame("en_gap_not_yet", 1'b0, 1'b0);
        step();
        check_frame("en_gap_ready", 1'b1, 1'b0);
        check_drop("en_gap_no_drops", 16'd0, 1'b0);
        frame_ack = 1'b1;
        step();
        check_frame("single_frame", 1'b0, 1'b0);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL missing_writes pending=%0d expected 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_hold_and_ack();
        test_overrun();
        test_ack_drop();
        test_async_reset();
        test_en_gap();
        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
